// File: rtl/wbi_vic_pkg.sv
// rtl/wbi_vic_pkg.sv - shared types and constants for the vectored interrupt controller
package wbi_vic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } vic_state_t;

    localparam logic [15:0] SPUR_VEC_DEFAULT = 16'o000000;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wbi_prio_enc.sv
// rtl/wbi_prio_enc.sv - fixed-priority encoder, lowest set index wins
module wbi_prio_enc
    import wbi_vic_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
)(
    input  logic [N-1:0]  eff,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the lowest-priority end so the lowest set index is written last.
    always_comb begin
        any = |eff;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eff[k]) idx = IW'(k);
        end
    end

endmodule

// File: rtl/wbi_vector_ctrl.sv
// rtl/wbi_vector_ctrl.sv - vectored interrupt responder for the CPU ivec/istb/iack/virq handshake
module wbi_vector_ctrl
    import wbi_vic_pkg::*;
#(
    parameter int          N        = 4,
    parameter logic [15:0] SPUR_VEC = SPUR_VEC_DEFAULT,
    parameter int          HOLD     = 2
)(
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic [N-1:0]    irq_req,
    input  logic [16*N-1:0] irq_vec,
    output logic [N-1:0]    irq_ack,
    output logic            virq,
    input  logic            istb,
    output logic [15:0]     ivec,
    output logic            iack
);

    localparam int IW = idx_width(N);
    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    vic_state_t    state;
    vic_state_t    state_nxt;
    logic [IW-1:0] winner;
    logic          spur;
    logic          abort_flag;
    logic [HW-1:0] hold_cnt [N];
    logic [N-1:0]  eff;
    logic [N-1:0]  excl;
    logic          any;
    logic [IW-1:0] idx;
    logic [15:0]   vec_sel;
    logic          take;

    // Requests from sources still in their post-ack hold window are ignored.
    always_comb begin
        eff = '0;
        for (int k = 0; k < N; k++) begin
            eff[k] = irq_req[k] & (hold_cnt[k] == '0);
        end
    end

    wbi_prio_enc #(.N(N), .IW(IW)) u_prio (
        .eff (eff),
        .any (any),
        .idx (idx)
    );

    // Vector of the current priority winner, or the spurious vector when nothing is pending.
    always_comb begin
        vec_sel = SPUR_VEC;
        for (int k = 0; k < N; k++) begin
            if (any && (idx == IW'(k))) vec_sel = irq_vec[16*k +: 16];
        end
    end

    // While a handshake is in flight the frozen winner no longer counts towards virq.
    always_comb begin
        excl = '0;
        if ((state != IDLE) && !spur) begin
            for (int k = 0; k < N; k++) begin
                if (winner == IW'(k)) excl[k] = 1'b1;
            end
        end
    end

    assign take = (state == RELEASE) && !istb && !spur && !abort_flag;

    // Handshake state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state: sample in IDLE, one ACK cycle, stay in RELEASE until the strobe drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istb) state_nxt = ACK;
            ACK:     state_nxt = RELEASE;
            RELEASE: if (!istb) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered CPU-side outputs, winner latch and the per-handshake flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ivec       <= '0;
            iack       <= 1'b0;
            irq_ack    <= '0;
            virq       <= 1'b0;
            winner     <= '0;
            spur       <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            irq_ack <= '0;
            virq    <= |(eff & ~excl);
            case (state)
                IDLE: begin
                    if (istb) begin
                        winner     <= idx;
                        spur       <= ~any;
                        abort_flag <= 1'b0;
                        ivec       <= vec_sel;
                    end
                end
                ACK: begin
                    iack <= 1'b1;
                    if (!istb) abort_flag <= 1'b1;
                end
                RELEASE: begin
                    if (!istb) begin
                        iack <= 1'b0;
                        ivec <= '0;
                        if (take) irq_ack <= N'(1) << winner;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold counters mask a serviced source while its device drops the request.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int k = 0; k < N; k++) hold_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (take && (winner == IW'(k)))  hold_cnt[k] <= HW'(HOLD);
                else if (hold_cnt[k] != '0)      hold_cnt[k] <= hold_cnt[k] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wbi_vector_ctrl.sv
// tb/tb_wbi_vector_ctrl.sv - self-checking bench for wbi_vector_ctrl
module tb_wbi_vector_ctrl;

    localparam int          NS   = 4;
    localparam int          HOLD = 2;
    localparam logic [15:0] SPUR = 16'o000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [15:0]   vec [4];
    logic [63:0]   irq_vec;
    logic [3:0]    irq_ack;
    logic          virq;
    logic          istb;
    logic [15:0]   ivec;
    logic          iack;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int last_ack [4];
    int w;

    assign irq_vec = {vec[3], vec[2], vec[1], vec[0]};

    wbi_vector_ctrl #(.N(NS), .SPUR_VEC(SPUR), .HOLD(HOLD)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .irq_req  (req),
        .irq_vec  (irq_vec),
        .irq_ack  (irq_ack),
        .virq     (virq),
        .istb     (istb),
        .ivec     (ivec),
        .iack     (iack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source k counts at clock edge t if it requests and its last service is more than HOLD edges back.
    function automatic logic [3:0] eff_at(input int t);
        logic [3:0] e;
        for (int k = 0; k < 4; k++) e[k] = req[k] && (t > last_ack[k] + HOLD);
        return e;
    endfunction

    function automatic int lowest(input logic [3:0] e);
        for (int k = 0; k < 4; k++) if (e[k]) return k;
        return -1;
    endfunction

    // Full handshake with the strobe held h extra cycles; optionally the device drops its request on ack.
    task automatic handshake(input int h, input bit drop, output int win);
        logic [3:0]  e;
        logic [3:0]  ex;
        logic [15:0] ev;
        istb = 1'b1;
        tick();
        e   = eff_at(edge_n);
        win = lowest(e);
        if (win < 0) begin ev = SPUR; ex = 4'b0000; end
        else begin ev = vec[win]; ex = 4'b0001 << win; end
        check("hs_virq_idle", virq, |e);
        check("hs_ivec_load", ivec, ev);
        check("hs_iack_early", iack, 0);
        tick();
        check("hs_iack_on", iack, 1);
        check("hs_ivec_ack", ivec, ev);
        check("hs_virq_ack", virq, |(eff_at(edge_n) & ~ex));
        for (int i = 0; i < h; i++) begin
            tick();
            check("hs_iack_hold", iack, 1);
            check("hs_ivec_hold", ivec, ev);
            check("hs_virq_hold", virq, |(eff_at(edge_n) & ~ex));
        end
        istb = 1'b0;
        tick();
        check("hs_iack_off", iack, 0);
        check("hs_ivec_off", ivec, 0);
        check("hs_irq_ack", irq_ack, ex);
        check("hs_virq_rel", virq, |(eff_at(edge_n) & ~ex));
        if (win >= 0) begin
            last_ack[win] = edge_n;
            if (drop) req[win] = 1'b0;
        end
        tick();
        check("hs_irq_ack_pulse", irq_ack, 0);
        check("hs_virq_after", virq, |eff_at(edge_n));
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        istb   = 1'b0;
        vec[0] = 16'o000044;
        vec[1] = 16'o000064;
        vec[2] = 16'o000060;
        vec[3] = 16'o000100;
        for (int k = 0; k < 4; k++) last_ack[k] = -100;

        repeat (3) tick();
        check("rst_virq", virq, 0);
        check("rst_iack", iack, 0);
        check("rst_ivec", ivec, 0);
        check("rst_irq_ack", irq_ack, 0);
        rst_n = 1'b1;
        tick();

        // Single source
        req = 4'b0100;
        tick();
        check("single_virq", virq, 1);
        handshake(1, 1'b0, w);
        check("single_win", w, 2);
        req = 4'b0000;
        tick();
        check("single_virq_hold", virq, 0);

        // Fixed priority
        req = 4'b1010;
        repeat (3) tick();
        handshake(0, 1'b1, w);
        check("prio_first", w, 1);
        repeat (2) tick();
        handshake(0, 1'b1, w);
        check("prio_second", w, 3);

        // Spurious: request withdrawn before the strobe
        req = 4'b0001;
        tick();
        check("spur_virq", virq, 1);
        req = 4'b0000;
        handshake(0, 1'b0, w);
        check("spur_win", w, -1);

        // Hold: device keeps its request one cycle after the ack
        req = 4'b0010;
        repeat (3) tick();
        handshake(0, 1'b0, w);
        check("hold_win", w, 1);
        req = 4'b0000;
        tick();
        check("hold_virq", virq, 0);

        // Freeze: a higher-priority request during ACK does not change the vector
        req = 4'b0100;
        repeat (3) tick();
        istb = 1'b1;
        tick();
        check("frz_ivec0", ivec, 16'o000060);
        req = 4'b0101;
        tick();
        check("frz_iack", iack, 1);
        check("frz_ivec1", ivec, 16'o000060);
        check("frz_virq", virq, 1);
        tick();
        check("frz_ivec2", ivec, 16'o000060);
        istb = 1'b0;
        tick();
        check("frz_irq_ack", irq_ack, 4'b0100);
        check("frz_ivec_off", ivec, 0);
        last_ack[2] = edge_n;
        req = 4'b0001;
        tick();
        check("frz_virq_after", virq, 1);
        handshake(0, 1'b1, w);
        check("frz_next_win", w, 0);

        // Abort: strobe dropped during ACK
        req = 4'b0010;
        repeat (3) tick();
        istb = 1'b1;
        tick();
        check("abort_ivec", ivec, 16'o000064);
        istb = 1'b0;
        tick();
        check("abort_iack_on", iack, 1);
        tick();
        check("abort_iack_off", iack, 0);
        check("abort_irq_ack", irq_ack, 0);
        check("abort_ivec_off", ivec, 0);
        tick();
        check("abort_virq_back", virq, 1);
        handshake(0, 1'b1, w);
        check("abort_retry_win", w, 1);

        // Reset in the middle of a handshake
        req = 4'b0001;
        repeat (3) tick();
        check("mid_virq", virq, 1);
        istb = 1'b1;
        tick();
        tick();
        check("mid_iack", iack, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_iack", iack, 0);
        check("mid_rst_ivec", ivec, 0);
        check("mid_rst_virq", virq, 0);
        check("mid_rst_irq_ack", irq_ack, 0);
        istb = 1'b0;
        for (int k = 0; k < 4; k++) last_ack[k] = -100;
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_virq", virq, 1);
        handshake(0, 1'b1, w);
        check("post_rst_win", w, 0);

        // Randomized handshakes against the reference model
        for (int it = 0; it < 40; it++) begin
            int n_idle;
            for (int k = 0; k < 4; k++) vec[k] = 16'($urandom);
            req    = 4'($urandom);
            n_idle = $urandom_range(0, 3);
            for (int i = 0; i < n_idle; i++) begin
                tick();
                check("rnd_virq", virq, |eff_at(edge_n));
            end
            handshake($urandom_range(0, 3), 1'b1, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wbi_vector_ctrl.md
Name: wbi_vector_ctrl

Overview:
- Vectored-interrupt responder: the slave end of the CPU's interrupt-vector handshake (wbi_stb / wbi_dat / wbi_ack).
- Collects level requests from N peripherals and drives the CPU's virq line.
- On the CPU's vector strobe, picks the highest-priority pending source, returns that source's vector, and acknowledges the CPU.
- Tells the winning peripheral its request was taken.
- Sits between the peripheral set and the processor module's ivec/istb/iack/virq pins.

Parameters:
N, 4, number of interrupt sources; index 0 = highest priority; 1..16.
SPUR_VEC, 16'o000000, vector returned if no request is pending when the strobe is sampled.
HOLD, 2, cycles a just-acknowledged source stays masked so the device has time to drop its request.

Ports:
wb_clk_i  in  1  system clock (clk_p domain)
wb_rst_n  in  1  reset, asynchronous, active-low
irq_req  in  N  level interrupt requests from devices, synchronous to wb_clk_i
irq_vec  in  16*N  per-source vectors; source k uses bits [16k+15:16k]
irq_ack  out  N  one-cycle pulse to the serviced source
virq  out  1  vectored-interrupt request to the CPU
istb  in  1  CPU vector-read strobe
ivec  out  16  vector data to the CPU
iack  out  1  vector acknowledge to the CPU

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: virq=0, ivec=0, iack=0, irq_ack=0, state=IDLE, all hold counters=0.
- Effective request: eff[k] = irq_req[k] & (hold_cnt[k]==0).
- virq (registered): |eff, updated every cycle; latency 1 clock.
- FSM states:
  - IDLE:
    - istb=1 → latch winner = lowest k with eff[k]=1.
    - ivec <= irq_vec[winner], or SPUR_VEC if eff==0; record a spurious flag.
    - Go to ACK. The winner is frozen here; later requests do not change ivec.
  - ACK:
    - iack <= 1 (asserted the 2nd clock after istb is sampled). Go to RELEASE.
  - RELEASE:
    - Hold iack=1 and ivec stable while istb=1.
    - When istb=0: iack <= 0, ivec <= 0.
    - If not spurious: irq_ack[winner] pulses for exactly 1 clock and hold_cnt[winner] <= HOLD.
    - Go to IDLE.
- hold_cnt[k]: decrements by 1 each clock while nonzero; saturates at 0.
- virq deassert: during ACK/RELEASE, virq excludes the frozen winner bit, so virq drops after the taken request unless another source is still pending.
- Simultaneous requests: strict fixed priority, lowest index wins. No round-robin.
- Request withdrawn between virq and istb: the controller still acks with SPUR_VEC and gives no irq_ack pulse. The CPU must never hang.
- istb dropped in ACK (protocol abort):
  - Go to RELEASE anyway; iack is still raised for 1 cycle, then cleared.
  - No irq_ack pulse, because the abort flag is set.
- Back-to-back strobe: istb re-asserted on the clock after RELEASE exits is sampled in IDLE normally; minimum cycle is 3 clocks plus the istb high time.
- Reset mid-handshake: everything clears immediately. iack drops even with istb high.
- Winner index width: clog2(N), minimum 1 bit.

Decomposition:
- Package wbi_vic_pkg holds:
  - state enum {IDLE, ACK, RELEASE}, 2-bit encoding;
  - SPUR_VEC default;
  - localparam function for the index width.
- One sub-module, wbi_prio_enc: parameter N; combinational; eff[N-1:0] → {any, idx}; lowest index first.
- Top module holds the FSM, hold counters and output registers.

Test Plan:
- Single source: N=4, irq_req=4'b0100, irq_vec[2]=16'o000060.
  - virq=1 one clock later.
  - istb 1 → ivec=16'o000060 and iack=1 on the 2nd clock.
  - istb 0 → iack=0, irq_ack=4'b0100 for 1 clock, virq=0 while hold runs.
- Priority: irq_req=4'b1010 with vectors 064 (src1) and 100 (src3).
  - First handshake returns 16'o000064.
  - Once src1 drops its request, the second handshake returns 16'o000100.
- Spurious: virq raised by src0, src0 drops before istb.
  - ivec=SPUR_VEC=0, iack=1, irq_ack stays 0.
- Freeze: src2 pending; during ACK, src0 asserts.
  - ivec stays src2's vector until istb falls.
  - virq stays 1 afterwards due to src0.
- Hold: device keeps irq_req[1]=1 for 1 cycle after irq_ack[1].
  - No second virq from src1 within HOLD=2 clocks.
- Reset: wb_rst_n=0 in RELEASE with istb=1 → iack, ivec, virq and irq_ack are all 0 asynchronously. After release, state is IDLE.
